// File: rtl/sys_issue_arbiter.sv
// Registered issue arbiter in front of the shared system unit.
// Picks one ready reservation station per cycle, oldest RS ID first, and force-grants any station that has waited too long.
module sys_issue_arbiter #(
  parameter int REQUESTERS   = 3,
  parameter int RS_ID_WIDTH  = 5,
  parameter int OP_WIDTH     = 32,
  parameter int CTRL_WIDTH   = 16,
  parameter int STARVE_LIMIT = 7
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic                          req_valid   [REQUESTERS],
  output logic                          req_ready   [REQUESTERS],
  input  logic [RS_ID_WIDTH-1:0]        req_rs_id   [REQUESTERS],
  input  logic [OP_WIDTH-1:0]           req_op      [REQUESTERS],
  input  logic [CTRL_WIDTH-1:0]         req_control [REQUESTERS],
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [RS_ID_WIDTH-1:0]        out_rs_id,
  output logic [OP_WIDTH-1:0]           out_op,
  output logic [CTRL_WIDTH-1:0]         out_control,
  output logic [$clog2(REQUESTERS)-1:0] out_src
);

  localparam int SRC_W  = $clog2(REQUESTERS);
  localparam int WAIT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(STARVE_LIMIT);

  logic [WAIT_W-1:0]      wait_cnt [REQUESTERS];
  logic                   load;
  logic                   accept;
  logic                   any_valid;
  logic                   any_starved;
  logic [SRC_W-1:0]       starve_idx;
  logic [SRC_W-1:0]       age_idx;
  logic [SRC_W-1:0]       sel_idx;
  logic [RS_ID_WIDTH-1:0] best_id;

  // Starved stations win by lowest index; otherwise smallest RS ID, ties to the lower index.
  always_comb begin
    any_starved = 1'b0;
    starve_idx  = '0;
    any_valid   = 1'b0;
    age_idx     = '0;
    best_id     = '0;
    for (int i = REQUESTERS - 1; i >= 0; i--) begin
      if (req_valid[i] && (wait_cnt[i] == WAIT_MAX)) begin
        any_starved = 1'b1;
        starve_idx  = SRC_W'(i);
      end
    end
    for (int i = 0; i < REQUESTERS; i++) begin
      if (req_valid[i] && (!any_valid || (req_rs_id[i] < best_id))) begin
        any_valid = 1'b1;
        best_id   = req_rs_id[i];
        age_idx   = SRC_W'(i);
      end
    end
    sel_idx = any_starved ? starve_idx : age_idx;
  end

  assign load   = !rst && !flush && (!out_valid || out_ready);
  assign accept = load && any_valid;

  always_comb begin
    for (int i = 0; i < REQUESTERS; i++) begin
      req_ready[i] = accept && (sel_idx == SRC_W'(i));
    end
  end

  // Output stage; a drain with a simultaneous accept simply overwrites the entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_rs_id   <= '0;
      out_op      <= '0;
      out_control <= '0;
      out_src     <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_src   <= sel_idx;
      for (int i = 0; i < REQUESTERS; i++) begin
        if (req_ready[i]) begin
          out_rs_id   <= req_rs_id[i];
          out_op      <= req_op[i];
          out_control <= req_control[i];
        end
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Wait counters keep counting through backpressure so starvation is tracked by time, not by grants.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < REQUESTERS; i++) wait_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < REQUESTERS; i++) begin
        if (flush || !req_valid[i] || req_ready[i]) begin
          wait_cnt[i] <= '0;
        end else if (wait_cnt[i] != WAIT_MAX) begin
          wait_cnt[i] <= wait_cnt[i] + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_sys_issue_arbiter.sv
// Self-checking bench for sys_issue_arbiter: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a behavioural model.
module tb_sys_issue_arbiter;

  localparam int N   = 3;
  localparam int IDW = 5;
  localparam int OPW = 32;
  localparam int CW  = 16;
  localparam int LIM = 7;

  logic           clk;
  logic           rst;
  logic           flush;
  logic           req_valid   [N];
  logic           req_ready   [N];
  logic [IDW-1:0] req_rs_id   [N];
  logic [OPW-1:0] req_op      [N];
  logic [CW-1:0]  req_control [N];
  logic           out_valid;
  logic           out_ready;
  logic [IDW-1:0] out_rs_id;
  logic [OPW-1:0] out_op;
  logic [CW-1:0]  out_control;
  logic [1:0]     out_src;

  int checks   = 0;
  int failures = 0;

  int             wait_m [N];
  bit             exp_valid;
  logic [IDW-1:0] exp_rs;
  logic [OPW-1:0] exp_op;
  logic [CW-1:0]  exp_ctrl;
  int             exp_src;

  sys_issue_arbiter #(
    .REQUESTERS(N), .RS_ID_WIDTH(IDW), .OP_WIDTH(OPW), .CTRL_WIDTH(CW), .STARVE_LIMIT(LIM)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_rs_id(req_rs_id),
    .req_op(req_op), .req_control(req_control),
    .out_valid(out_valid), .out_ready(out_ready), .out_rs_id(out_rs_id),
    .out_op(out_op), .out_control(out_control), .out_src(out_src)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Winner per the arbitration rules: first starved index, else smallest ID (earliest index on ties).
  function automatic int pick();
    int best;
    for (int i = 0; i < N; i++) if (req_valid[i] && wait_m[i] == LIM) return i;
    best = -1;
    for (int i = 0; i < N; i++)
      if (req_valid[i] && (best < 0 || int'(req_rs_id[i]) < int'(req_rs_id[best]))) best = i;
    return best;
  endfunction

  function automatic logic [2:0] ready_vec();
    return {req_ready[2], req_ready[1], req_ready[0]};
  endfunction

  task automatic model_reset();
    exp_valid = 1'b0;
    exp_rs    = '0;
    exp_op    = '0;
    exp_ctrl  = '0;
    exp_src   = 0;
    for (int i = 0; i < N; i++) wait_m[i] = 0;
  endtask

  // Compare on the falling edge, then advance the model with the inputs the next rising edge will see.
  always @(negedge clk) begin
    if (rst) begin
      model_reset();
    end else begin
      int g;
      bit ld;
      g  = pick();
      ld = !flush && (!exp_valid || out_ready);
      for (int i = 0; i < N; i++)
        checkOutput($sformatf("req_ready[%0d]", i), 64'(req_ready[i]), 64'(ld && g == i));
      checkOutput("out_valid", 64'(out_valid), 64'(exp_valid));
      if (exp_valid) begin
        checkOutput("out_rs_id", 64'(out_rs_id), 64'(exp_rs));
        checkOutput("out_op", 64'(out_op), 64'(exp_op));
        checkOutput("out_control", 64'(out_control), 64'(exp_ctrl));
        checkOutput("out_src", 64'(out_src), 64'(exp_src));
      end
      if (flush) begin
        exp_valid = 1'b0;
        for (int i = 0; i < N; i++) wait_m[i] = 0;
      end else begin
        for (int i = 0; i < N; i++) begin
          if (!req_valid[i] || (ld && g == i)) wait_m[i] = 0;
          else if (wait_m[i] < LIM) wait_m[i] = wait_m[i] + 1;
        end
        if (ld && g >= 0) begin
          exp_valid = 1'b1;
          exp_rs    = req_rs_id[g];
          exp_op    = req_op[g];
          exp_ctrl  = req_control[g];
          exp_src   = g;
        end else if (out_ready) begin
          exp_valid = 1'b0;
        end
      end
    end
  end

  task automatic applyStimulus(input logic [2:0] v, input int id0, input int id1, input int id2,
                               input logic ordy, input logic fl);
    int ids [N];
    ids = '{id0, id1, id2};
    for (int i = 0; i < N; i++) begin
      req_valid[i]   = v[i];
      req_rs_id[i]   = IDW'(ids[i]);
      req_op[i]      = 32'h1000_0000 | OPW'(i);
      req_control[i] = CW'(16'h0100 + i);
    end
    out_ready = ordy;
    flush     = fl;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(3'b000, 0, 0, 0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("reset out_valid", 64'(out_valid), 64'd0);
    checkOutput("reset out_rs_id", 64'(out_rs_id), 64'd0);
    checkOutput("reset out_op", 64'(out_op), 64'd0);
    checkOutput("reset out_control", 64'(out_control), 64'd0);
    checkOutput("reset out_src", 64'(out_src), 64'd0);

    // Single request from the SPR station
    nextCycle();
    applyStimulus(3'b010, 0, 9, 0, 1'b1, 1'b0);
    req_op[1] = 32'hDEAD_BEEF;
    @(negedge clk);
    checkOutput("single ready", 64'(ready_vec()), 64'b010);
    nextCycle();
    applyStimulus(3'b000, 0, 0, 0, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("single out_valid", 64'(out_valid), 64'd1);
    checkOutput("single out_rs_id", 64'(out_rs_id), 64'd9);
    checkOutput("single out_op", 64'(out_op), 64'hDEAD_BEEF);
    checkOutput("single out_src", 64'(out_src), 64'd1);

    // Age pick: 12/4/4 grants 1, then 2, then 0
    nextCycle();
    applyStimulus(3'b111, 12, 4, 4, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("age grant1", 64'(ready_vec()), 64'b010);
    nextCycle();
    applyStimulus(3'b101, 12, 4, 4, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("age grant2", 64'(ready_vec()), 64'b100);
    checkOutput("age src1", 64'(out_src), 64'd1);
    nextCycle();
    applyStimulus(3'b001, 12, 4, 4, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("age grant0", 64'(ready_vec()), 64'b001);
    checkOutput("age src2", 64'(out_src), 64'd2);

    // Backpressure: entry from req0 (rs 12) held while req0 re-requests
    for (int c = 0; c < 5; c++) begin
      nextCycle();
      applyStimulus(3'b001, 7, 0, 0, 1'b0, 1'b0);
      @(negedge clk);
      checkOutput("bp ready", 64'(ready_vec()), 64'b000);
      checkOutput("bp out_rs_id", 64'(out_rs_id), 64'd12);
      checkOutput("bp out_src", 64'(out_src), 64'd0);
    end
    nextCycle();
    checkOutput("bp model wait0", 64'(wait_m[0]), 64'd5);
    applyStimulus(3'b001, 7, 0, 0, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("bp release ready", 64'(ready_vec()), 64'b001);

    // Starvation: req0 (rs 20) loses to req1 (rs 1) until its 8th cycle
    nextCycle();
    applyStimulus(3'b000, 0, 0, 0, 1'b1, 1'b0);
    for (int c = 1; c <= 9; c++) begin
      nextCycle();
      applyStimulus(3'b011, 20, 1, 0, 1'b1, 1'b0);
      @(negedge clk);
      checkOutput($sformatf("starve cycle%0d", c), 64'(ready_vec()), (c == 8) ? 64'b001 : 64'b010);
    end

    // Drain and reload in the same cycle
    nextCycle();
    applyStimulus(3'b100, 0, 0, 3, 1'b1, 1'b0);
    req_op[2] = 32'h5555_5555;
    @(negedge clk);
    checkOutput("replace ready", 64'(ready_vec()), 64'b100);
    checkOutput("replace prev valid", 64'(out_valid), 64'd1);

    // Flush while holding the replaced entry
    nextCycle();
    applyStimulus(3'b100, 0, 0, 3, 1'b1, 1'b1);
    @(negedge clk);
    checkOutput("replace out_valid", 64'(out_valid), 64'd1);
    checkOutput("replace out_src", 64'(out_src), 64'd2);
    checkOutput("replace out_op", 64'(out_op), 64'h5555_5555);
    checkOutput("flush ready", 64'(ready_vec()), 64'b000);
    nextCycle();
    applyStimulus(3'b000, 0, 0, 0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("flush out_valid", 64'(out_valid), 64'd0);

    // Async reset mid-cycle drops a held entry before the next edge
    nextCycle();
    applyStimulus(3'b001, 2, 0, 0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("pre-reset ready", 64'(ready_vec()), 64'b001);
    nextCycle();
    @(negedge clk);
    checkOutput("pre-reset out_valid", 64'(out_valid), 64'd1);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    checkOutput("async out_valid", 64'(out_valid), 64'd0);
    checkOutput("async ready", 64'(ready_vec()), 64'b000);
    nextCycle();
    rst = 1'b0;
    applyStimulus(3'b000, 0, 0, 0, 1'b0, 1'b0);

    // Randomized traffic with sticky-ish valids, small ID space for ties, occasional flush
    for (int c = 0; c < 1500; c++) begin
      nextCycle();
      for (int i = 0; i < N; i++) begin
        req_valid[i]   = ($urandom_range(0, 7) != 0);
        req_rs_id[i]   = IDW'($urandom_range(0, 7));
        req_op[i]      = $urandom;
        req_control[i] = CW'($urandom);
      end
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 24) == 0);
    end
    nextCycle();
    applyStimulus(3'b000, 0, 0, 0, 1'b1, 1'b0);
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
